// File: rtl/systolic_feed_scheduler_if.sv
// Control and datapath-facing signals of the systolic feed scheduler.
// The slave modport is the scheduler; the master modport is the TPU control
// side that issues starts and the write-out SRAM side that returns ready.
interface systolic_feed_scheduler_if #(
  parameter int array_size = 8
);
  localparam int IW = $clog2(array_size);

  logic                  tpu_start;
  logic [8:0]            k_len;
  logic                  wr_ready;
  logic [array_size-1:0] data_start;
  logic [array_size-1:0] weight_start;
  logic                  alu_start;
  logic [8:0]            cycle_num;
  logic                  sram_write_enable;
  logic [IW-1:0]         matrix_index;
  logic                  busy;
  logic                  tpu_done;

  modport master (
    output tpu_start, k_len, wr_ready,
    input  data_start, weight_start, alu_start, cycle_num,
           sram_write_enable, matrix_index, busy, tpu_done
  );

  modport slave (
    input  tpu_start, k_len, wr_ready,
    output data_start, weight_start, alu_start, cycle_num,
           sram_write_enable, matrix_index, busy, tpu_done
  );
endinterface

// File: rtl/systolic_feed_scheduler.sv
// Sequences one matrix-multiply pass through an N x N systolic array:
// diagonally skewed FIFO pop enables while feeding, a drain window so the
// last partial sums reach the array edge, then a row-by-row write-out to
// the result SRAM under a ready handshake. Every output is decoded from
// registered state only, so no input reaches an output combinationally.
module systolic_feed_scheduler #(
  parameter int datawith   = 16,
  parameter int array_size = 8
) (
  input logic                      clk,
  input logic                      rst,
  systolic_feed_scheduler_if.slave bus
);
  localparam int N  = array_size;
  localparam int IW = $clog2(array_size);

  if (datawith < 1 || array_size < 2 || array_size > 16) begin : g_param_check
    $error("systolic_feed_scheduler: datawith must be >= 1 and array_size within 2..16");
  end

  typedef enum logic [2:0] {
    IDLE,
    FEED,
    DRAIN,
    WRITE,
    DONE
  } state_t;

  state_t        state, state_next;
  logic [8:0]    c, c_next;
  logic [IW-1:0] row, row_next;
  logic [8:0]    k_lat, k_next;
  logic [8:0]    k_eff;
  logic [9:0]    feed_last;
  logic [9:0]    drain_last;
  logic [N-1:0]  feed_mask;

  // K of zero still needs one operand beat; anything past 256 is capped
  assign k_eff = (bus.k_len == 9'd0)   ? 9'd1   :
                 (bus.k_len > 9'd256)  ? 9'd256 : bus.k_len;

  // Last compute cycle of the feed window and of the drain window
  assign feed_last  = {1'b0, k_lat} + 10'(N - 2);
  assign drain_last = {1'b0, k_lat} + 10'(2 * N - 3);

  // State, compute counter, write-out row and latched depth
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      c     <= '0;
      row   <= '0;
      k_lat <= '0;
    end else begin
      state <= state_next;
      c     <= c_next;
      row   <= row_next;
      k_lat <= k_next;
    end
  end

  // Pass sequencing; starts outside IDLE are simply not looked at
  always_comb begin
    state_next = state;
    c_next     = c;
    row_next   = row;
    k_next     = k_lat;
    case (state)
      IDLE: begin
        c_next   = '0;
        row_next = '0;
        if (bus.tpu_start) begin
          k_next     = k_eff;
          state_next = FEED;
        end
      end
      FEED: begin
        c_next = c + 9'd1;
        if ({1'b0, c} == feed_last) state_next = DRAIN;
      end
      DRAIN: begin
        c_next = c + 9'd1;
        if ({1'b0, c} == drain_last) begin
          state_next = WRITE;
          c_next     = '0;
          row_next   = '0;
        end
      end
      WRITE: begin
        if (bus.wr_ready) begin
          if (row == IW'(N - 1)) state_next = DONE;
          else                   row_next   = row + IW'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Row/column i pops while i <= c < i+K, giving the diagonal skew
  always_comb begin
    feed_mask = '0;
    for (int i = 0; i < N; i++) begin
      if (state == FEED && {1'b0, c} >= 10'(i) && {1'b0, c} < 10'(i) + {1'b0, k_lat})
        feed_mask[i] = 1'b1;
    end
  end

  assign bus.data_start        = feed_mask;
  assign bus.weight_start      = feed_mask;
  assign bus.alu_start         = (state == FEED) || (state == DRAIN);
  assign bus.cycle_num         = bus.alu_start ? c : 9'd0;
  assign bus.sram_write_enable = (state == WRITE);
  assign bus.matrix_index      = (state == WRITE) ? row : '0;
  assign bus.busy              = (state != IDLE);
  assign bus.tpu_done          = (state == DONE);
endmodule
